// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: two-entry skid buffer between pipeline stages.
// The main entry drives the outputs; the skid entry catches one instruction
// when downstream stalls, so in_ready can come straight from a flop.
// A flush squashes both entries. A saturating counter tracks stall cycles.
//
// state | meaning
// EMPTY | no entry held
// ONE   | main entry valid, skid empty
// FULL  | main and skid entries valid, in_ready low
module pipe_stage_buffer #(
  parameter int PAYLOAD_W = 160,
  parameter int CTRL_W    = 24,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                 state;
  logic                   main_valid;
  logic [PAYLOAD_W-1:0]   main_payload;
  logic [CTRL_W-1:0]      main_ctrl;
  logic                   skid_valid;
  logic [PAYLOAD_W-1:0]   skid_payload;
  logic [CTRL_W-1:0]      skid_ctrl;
  logic                   in_fire;
  logic                   out_fire;

  // skid_valid is a flop, so in_ready has no combinational input path
  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_payload = main_payload;
  assign out_ctrl    = main_valid ? main_ctrl : '0;
  assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;

  // Entry storage and state transitions; flush overrides everything
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= EMPTY;
      main_valid   <= 1'b0;
      main_payload <= '0;
      main_ctrl    <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
      skid_ctrl    <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_valid   <= 1'b1;
            main_payload <= in_payload;
            main_ctrl    <= in_ctrl;
            state        <= ONE;
          end
        end
        ONE: begin
          if (out_fire && in_fire) begin
            main_payload <= in_payload;
            main_ctrl    <= in_ctrl;
          end else if (out_fire) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            state      <= EMPTY;
          end else if (in_fire) begin
            skid_valid   <= 1'b1;
            skid_payload <= in_payload;
            skid_ctrl    <= in_ctrl;
            state        <= FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain case matters
          if (out_fire) begin
            main_payload <= skid_payload;
            main_ctrl    <= skid_ctrl;
            skid_valid   <= 1'b0;
            skid_ctrl    <= '0;
            state        <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles where downstream holds off a valid head
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
